// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath constants and regfile dumper state encodings.
package mips_pkg;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/regfile_dumper_if.sv
// Output beat stream of the regfile dumper: (index, value) with valid/ready.
interface regfile_dumper_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_idx, output out_data, input out_ready);
    modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/regfile_dumper.sv
// Walks first_idx..last_idx through one register file read port and streams
// each (index, value) pair out. Only a read address is driven, so
// architectural state is never touched.
module regfile_dumper
    import mips_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = WORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_idx,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                abort,
    output logic [ADDR_W-1:0]   rf_addr,
    input  logic [DATA_W-1:0]   rf_data,
    regfile_dumper_if.master    dout,
    output logic                busy,
    output logic                done
);
    // One extra bit so the range limit is representable even when
    // NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic              range_ok;

    assign range_ok = (first_idx <= last_idx) && ({1'b0, last_idx} < LIMIT);

    // FSM, index counter and beat capture register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            last        <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= first_idx;
                        last  <= last_idx;
                        state <= range_ok ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        // Value seen here is pre-edge contents; a same-edge
                        // write to idx lands after the capture.
                        out_data_q  <= rf_data;
                        out_idx_q   <= idx;
                        out_valid_q <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (dout.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx == last) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_READ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered read address simply follows the index counter.
    assign rf_addr        = idx;
    assign dout.out_valid = out_valid_q;
    assign dout.out_idx   = out_idx_q;
    assign dout.out_data  = out_data_q;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE) && !abort;
endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with a behavioural register file on the
// read port and a scoreboard queue of expected beats.
module tb_regfile_dumper;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [4:0]  first_idx, last_idx, rf_addr;
    logic [31:0] rf_data;
    logic        busy, done;
    logic [31:0] rf [32];
    beat_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          n;

    regfile_dumper_if #(.ADDR_W(5), .DATA_W(32)) dif ();

    regfile_dumper dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx),
        .last_idx(last_idx), .abort(abort), .rf_addr(rf_addr),
        .rf_data(rf_data), .dout(dif), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // r0 is hard-wired to zero like the real register file.
    assign rf_data = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && !abort && dif.out_valid && dif.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_beat observed idx=%0d data=%0h expected no beat",
                       dif.out_idx, dif.out_data);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_idx", 64'(dif.out_idx), 64'(e.idx));
                chk("beat_data", 64'(dif.out_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++)
            q.push_back('{idx: i[4:0], data: (i == 0) ? 32'd0 : rf[i]});
    endtask

    task automatic start_dump(input int f, input int l);
        first_idx = f[4:0];
        last_idx  = l[4:0];
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done && cyc < 200);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0; dif.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hdead_0000 + 32'(i);
        step(); step();
        chk("rst_valid", 64'(dif.out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_addr", 64'(rf_addr), 0);
        chk("rst_idx", 64'(dif.out_idx), 0);
        chk("rst_data", 64'(dif.out_data), 0);
        rst_n = 1'b1;
        step();

        // Two-register dump, latency and done timing.
        rf[17] = 32'd12; rf[18] = 32'd7;
        dif.out_ready = 1'b1;
        push_range(17, 18);
        start_dump(17, 18);
        chk("t1_valid_c1", 64'(dif.out_valid), 0);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_addr", 64'(rf_addr), 17);
        step();
        chk("t1_valid_c2", 64'(dif.out_valid), 1);
        chk("t1_idx_c2", 64'(dif.out_idx), 17);
        chk("t1_data_c2", 64'(dif.out_data), 12);
        wait_done(n);
        chk("t1_done_cyc", 64'(n), 3);
        chk("t1_q_empty", 64'(q.size()), 0);
        step();
        chk("t1_done_one", 64'(done), 0);
        chk("t1_idle", 64'(busy), 0);

        // Full 0..31 dump.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        rf[0] = 32'h5555_aaaa;
        push_range(0, 31);
        start_dump(0, 31);
        wait_done(n);
        chk("t2_done_cyc", 64'(n), 64);
        chk("t2_q_empty", 64'(q.size()), 0);
        step();

        // Backpressure on a single beat; value must not be re-read.
        rf[18] = 32'd7;
        dif.out_ready = 1'b0;
        push_range(18, 18);
        start_dump(18, 18);
        step();
        rf[18] = 32'd55;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 64'(dif.out_valid), 1);
            chk("t3_hold_idx", 64'(dif.out_idx), 18);
            chk("t3_hold_data", 64'(dif.out_data), 7);
            step();
        end
        rf[18] = 32'd7;
        dif.out_ready = 1'b1;
        chk("t3_last_valid", 64'(dif.out_valid), 1);
        chk("t3_last_data", 64'(dif.out_data), 7);
        wait_done(n);
        chk("t3_done_cyc", 64'(n), 1);
        chk("t3_q_empty", 64'(q.size()), 0);
        step();

        // Empty range.
        start_dump(5, 4);
        chk("t4_done", 64'(done), 1);
        chk("t4_busy", 64'(busy), 1);
        chk("t4_valid", 64'(dif.out_valid), 0);
        step();
        chk("t4_done_gone", 64'(done), 0);
        chk("t4_busy_gone", 64'(busy), 0);

        // Abort while stalled at idx 20 of 16..25.
        push_range(16, 19);
        start_dump(16, 25);
        n = 0;
        while (!(dif.out_valid && dif.out_idx == 5'd20) && n < 100) begin
            step();
            n++;
        end
        chk("t5_reach20", 64'(dif.out_idx), 20);
        dif.out_ready = 1'b0;
        abort = 1'b1;
        chk("t5_done_abort", 64'(done), 0);
        step();
        abort = 1'b0;
        chk("t5_valid", 64'(dif.out_valid), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_done", 64'(done), 0);
        chk("t5_q_empty", 64'(q.size()), 0);
        dif.out_ready = 1'b1;
        push_range(16, 16);
        start_dump(16, 16);
        wait_done(n);
        chk("t5_restart_cyc", 64'(n), 2);
        chk("t5_restart_q", 64'(q.size()), 0);
        step();

        // Start while busy is ignored.
        push_range(3, 4);
        start_dump(3, 4);
        first_idx = 5'd10; last_idx = 5'd12; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        chk("t6_done_cyc", 64'(n), 3);
        chk("t6_q_empty", 64'(q.size()), 0);
        step();
        step();
        chk("t6_no_restart", 64'(busy), 0);

        // Reset during SEND.
        dif.out_ready = 1'b0;
        start_dump(3, 6);
        step();
        chk("t7_in_send", 64'(dif.out_valid), 1);
        rst_n = 1'b0;
        step();
        chk("t7_valid", 64'(dif.out_valid), 0);
        chk("t7_idx", 64'(dif.out_idx), 0);
        chk("t7_data", 64'(dif.out_data), 0);
        chk("t7_addr", 64'(rf_addr), 0);
        chk("t7_busy", 64'(busy), 0);
        chk("t7_done", 64'(done), 0);
        rst_n = 1'b1;
        step();
        step();
        chk("t7_after_busy", 64'(busy), 0);
        chk("done_pulses", 64'(done_cnt), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_dumper.md
Name: regfile_dumper

Overview:
Sequential reader that walks a contiguous range of the 32x32 register file through one of its asynchronous read ports. It streams each (index, value) pair out over a valid/ready interface. It is used for debug dumps and end-of-test state checks in the single-cycle MIPS32 datapath, and is the read-side counterpart of the register file's write port. The block only drives a read address, so it never disturbs architectural state.

Parameters:
NUM_REGS, 32, number of architectural registers; index range is 0..NUM_REGS-1.
ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS.
DATA_W, 32, register data width.

Ports:
clk  input  1  rising-edge clock, shared with the register file
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request a dump; sampled only in IDLE
first_idx  input  ADDR_W  first register index; latched on accepted start
last_idx  input  ADDR_W  last register index, inclusive; latched on accepted start
abort  input  1  cancel an in-progress dump
rf_addr  output  ADDR_W  read address to a register file read port (a1 or a2)
rf_data  input  DATA_W  combinational read data returned for rf_addr
out_valid  output  1  out_idx/out_data beat is valid
out_ready  input  1  consumer accepts the beat
out_idx  output  ADDR_W  register index of the current beat
out_data  output  DATA_W  captured register value
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst_n=0 at a rising clk edge): state=IDLE, all outputs 0 (rf_addr, out_idx, out_data, out_valid, busy, done). Reset mid-dump abandons the dump immediately, with no done pulse.
- States: IDLE, READ, SEND, DONE. The state register and the idx counter are the only sequential control.
- IDLE: start=1 latches first_idx into idx and last_idx into last.
  - If first_idx <= last_idx: go to READ.
  - If first_idx > last_idx or last_idx >= NUM_REGS: go to DONE, emitting zero beats.
- READ: rf_addr=idx. At the clock edge, out_data<=rf_data, out_idx<=idx, out_valid<=1, then go to SEND. The captured value is the register contents during the READ cycle. A same-cycle register write to idx is not seen, because the register file updates on the same edge.
- SEND: out_valid=1. out_idx and out_data are held stable until out_ready=1.
  - On handshake (out_valid&&out_ready) with idx==last: out_valid<=0, go to DONE.
  - On handshake with idx!=last: idx<=idx+1, out_valid<=0, go to READ.
- DONE: done=1 for exactly this one cycle, then go to IDLE. busy=1 in DONE.
- Throughput: one beat per 2 cycles minimum. Latency from accepted start to first out_valid is 2 cycles.
- rf_addr is registered and tracks idx. It stays at its last value in IDLE, which is harmless because the read port has no side effects.
- start while busy=1 is ignored and not queued. A start in the same cycle that DONE is reached is ignored. A start in the cycle after DONE (state is IDLE) is accepted.
- abort=1 in READ, SEND or DONE: next state is IDLE, out_valid<=0, done not pulsed. Dropping out_valid without a handshake is permitted only on abort. abort in IDLE has no effect. abort has priority over handshake.
- idx never wraps. The range check at start guarantees idx<=last<NUM_REGS.
- Index 0 is dumped like any other index; its value is whatever the register file returns (always 0).

Decomposition:
- Shared package mips_pkg: REG_COUNT=32, REG_ADDR_W=5, WORD_W=32 (parameter defaults taken from these), and dumper state encodings ST_IDLE=2'd0, ST_READ=2'd1, ST_SEND=2'd2, ST_DONE=2'd3.
- No sub-module. The capture register and FSM are small enough to keep inline. The bench pairs the block with the existing register file on its a1 port.

Test Plan:
- Preload r17=12, r18=7; start first=17,last=18, out_ready=1 -> beats (17,12),(18,7); out_valid first high at cycle 2 after start; done pulses once, 1 cycle after second handshake.
- Full dump 0..31 with all registers preloaded to (i*3), out_ready=1 -> 32 beats in order, out_data=i*3, r0 beat=0, total 65 cycles start-to-done inclusive.
- Backpressure: first=last=18, out_ready held 0 for 5 cycles then 1 -> out_valid/out_idx=18/out_data=7 stable for all 6 cycles; one beat only.
- Empty range: first=5,last=4 -> no out_valid ever; done pulses 1 cycle after start; busy high exactly 1 cycle.
- Abort in SEND at idx=20 of 16..25 with out_ready=0 -> next cycle state IDLE, out_valid=0, busy=0, no done; a new start 16..16 then completes normally.
- rst_n=0 for one cycle during SEND -> all outputs 0 next cycle; start ignored while busy (second start mid-dump produces no extra beats).
